// File: rtl/soc_system_hex_flash_ctrl.sv
// Registered seven-segment pass-through that blinks the digits software just
// changed, so that score and timer updates are visible to the player.
module soc_system_hex_flash_ctrl #(
  parameter int NUM_DIGITS  = 3,
  parameter int TICK_DIV    = 25000000,
  parameter int FLASH_COUNT = 3,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    busy
);

  localparam int W  = 7 * NUM_DIGITS;
  localparam int TW = $clog2(TICK_DIV);
  localparam int FW = $clog2(FLASH_COUNT + 1);

  localparam logic [6:0]    BLANK     = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [W-1:0]  BLANK_ALL = {NUM_DIGITS{BLANK}};
  localparam logic [TW-1:0] TICK_LOAD = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FC_LOAD   = FW'(FLASH_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OFF  = 2'd1,
    ON   = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [NUM_DIGITS-1:0] mask, mask_n, chg;
  logic [TW-1:0]         tick, tick_n;
  logic [FW-1:0]         fc, fc_n;
  logic [W-1:0]          seg_q, hex_n;
  logic                  primed;

  // primed suppresses change detection on the first sample after reset.
  always_comb begin
    chg = '0;
    for (int d = 0; d < NUM_DIGITS; d++)
      chg[d] = primed && (seg_in[7*d +: 7] != seg_q[7*d +: 7]);
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned (which would infer a latch); combinational logic uses blocking '='.
  always_comb begin
    state_n = state;
    mask_n  = mask;
    tick_n  = tick;
    fc_n    = fc;
    if (!enable) begin
      state_n = IDLE;
      mask_n  = '0;
    end else if (|chg) begin
      // A new change restarts the whole sequence and wins over tick expiry.
      state_n = OFF;
      mask_n  = mask | chg;
      fc_n    = FC_LOAD;
      tick_n  = TICK_LOAD;
    end else begin
      case (state)
        OFF: begin
          if (tick == '0) begin
            tick_n  = TICK_LOAD;
            state_n = ON;
          end else begin
            tick_n = tick - 1'b1;
          end
        end
        ON: begin
          if (tick == '0) begin
            fc_n = fc - 1'b1;
            if (fc == FW'(1)) begin
              state_n = IDLE;
              mask_n  = '0;
            end else begin
              tick_n  = TICK_LOAD;
              state_n = OFF;
            end
          end else begin
            tick_n = tick - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Gating with enable makes an abort show steady digits on the very next edge.
  always_comb begin
    hex_n = seg_q;
    for (int d = 0; d < NUM_DIGITS; d++)
      if (enable && (state == OFF) && mask[d])
        hex_n[7*d +: 7] = BLANK;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mask    <= '0;
      tick    <= '0;
      fc      <= '0;
      seg_q   <= BLANK_ALL;
      primed  <= 1'b0;
      hex_out <= BLANK_ALL;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      mask    <= mask_n;
      tick    <= tick_n;
      fc      <= fc_n;
      seg_q   <= seg_in;
      primed  <= 1'b1;
      hex_out <= hex_n;
      busy    <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_soc_system_hex_flash_ctrl.sv
// Self-checking bench: an active-low and an active-high instance share stimulus
// and are compared every cycle against an elapsed-time model of the blink rules.
module tb_soc_system_hex_flash_ctrl;

  localparam int TD = 4;
  localparam int FC = 2;
  localparam int ND = 3;
  localparam int W  = 7 * ND;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] seg_in;
  logic [W-1:0] hex_al, hex_ah;
  logic         busy_al, busy_ah;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  logic [W-1:0]  m_q;
  bit            m_q_blank;
  bit            m_primed;
  bit            m_active;
  logic [ND-1:0] m_mask;
  int            m_el;
  logic [W-1:0]  e_hex_al, e_hex_ah;
  logic          e_busy;

  always #5 clk = ~clk;

  soc_system_hex_flash_ctrl #(
    .NUM_DIGITS(ND), .TICK_DIV(TD), .FLASH_COUNT(FC), .ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .reset(reset), .enable(enable), .seg_in(seg_in),
    .hex_out(hex_al), .busy(busy_al)
  );

  soc_system_hex_flash_ctrl #(
    .NUM_DIGITS(ND), .TICK_DIV(TD), .FLASH_COUNT(FC), .ACTIVE_LOW(0)
  ) dut_ah (
    .clk(clk), .reset(reset), .enable(enable), .seg_in(seg_in),
    .hex_out(hex_ah), .busy(busy_ah)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle %0d: observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // A sequence lasts 2*FC*TD cycles from its latest (re)start; the first TD
  // cycles of every 2*TD window are the blanked half.
  task automatic model_edge();
    logic [ND-1:0] chg;
    bit            off;
    if (reset) begin
      m_primed  = 0;
      m_active  = 0;
      m_mask    = '0;
      m_q_blank = 1;
      m_el      = 0;
      e_hex_al  = {W{1'b1}};
      e_hex_ah  = '0;
      e_busy    = 1'b0;
    end else begin
      chg = '0;
      for (int d = 0; d < ND; d++) begin
        chg[d] = m_primed && (seg_in[7*d +: 7] != m_q[7*d +: 7]);
        off = enable && m_active && m_mask[d] && (((m_el / TD) % 2) == 0);
        e_hex_al[7*d +: 7] = (off || m_q_blank) ? 7'h7F : m_q[7*d +: 7];
        e_hex_ah[7*d +: 7] = (off || m_q_blank) ? 7'h00 : m_q[7*d +: 7];
      end
      if (!enable) begin
        m_active = 0;
        m_mask   = '0;
      end else if (chg != '0) begin
        m_mask   = m_active ? (m_mask | chg) : chg;
        m_active = 1;
        m_el     = 0;
      end else if (m_active) begin
        m_el++;
        if (m_el == 2 * FC * TD) begin
          m_active = 0;
          m_mask   = '0;
        end
      end
      m_q       = seg_in;
      m_q_blank = 0;
      m_primed  = 1;
      e_busy    = m_active;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("hex_active_low",  hex_al, e_hex_al);
    check("hex_active_high", hex_ah, e_hex_ah);
    check("busy_active_low",  {{(W-1){1'b0}}, busy_al}, {{(W-1){1'b0}}, e_busy});
    check("busy_active_high", {{(W-1){1'b0}}, busy_ah}, {{(W-1){1'b0}}, e_busy});
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_digit(input int d, input logic [6:0] v);
    seg_in[7*d +: 7] = v;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    seg_in = '0;
    // Reset, then the post-reset PIO value must not blink.
    run(3);
    reset = 1'b0;
    run(4);
    // Single-digit update, full sequence, then a second value.
    set_digit(0, 7'h40);
    run(20);
    set_digit(0, 7'h79);
    run(20);
    // Second digit changes during an ON phase: mask grows, count restarts.
    set_digit(0, 7'h12);
    run(6);
    set_digit(2, 7'h3F);
    run(20);
    // Abort by dropping enable mid-OFF; re-raise without a change.
    set_digit(1, 7'h06);
    run(2);
    enable = 1'b0;
    run(2);
    enable = 1'b1;
    run(4);
    // Digit changed then restored stays in the mask.
    set_digit(1, 7'h5B);
    run(1);
    set_digit(1, 7'h06);
    run(20);
    // One-cycle reset in the middle of an OFF phase.
    set_digit(0, 7'h24);
    run(2);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(4);
    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) < 2)
        set_digit(int'($urandom_range(0, ND - 1)), 7'($urandom_range(0, 127)));
      enable = ($urandom_range(0, 31) != 0);
      reset  = ($urandom_range(0, 127) == 0);
      step();
    end
    reset  = 1'b0;
    enable = 1'b1;
    run(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
